// File: rtl/seq_scan_ctrl_pkg.sv
// Shared state codes and flag constants for the serial pattern scan controller.
package seq_scan_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic FOUND    = 1'b1;
  localparam logic NOTFOUND = 1'b0;
endpackage

// File: rtl/seq_match_window.sv
// Serial shift window with fill tracking; flags a hit on the post-shift window.
module seq_match_window #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL    = FW'(PAT_W);
  localparam logic [FW-1:0] FULL_M1 = FW'(PAT_W - 1);

  logic [PAT_W-1:0] r_win;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] w_win_nxt;
  logic             w_full_nxt;

  assign w_win_nxt  = {r_win[PAT_W-2:0], bit_in};
  assign w_full_nxt = (r_fill >= FULL_M1);
  assign hit = shift && w_full_nxt && (w_win_nxt == pattern);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_win <= w_win_nxt;
      if (r_fill < FULL)
        r_fill <= r_fill + FW'(1);
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame-scoped serial pattern scan: arms on start, counts overlapping
// matches over frame_len valid bits, then pulses done.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);
  state_t           r_state;
  state_t           w_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bitcnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_found;
  logic             r_pulse;
  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic             w_hit;

  assign w_start  = (r_state == ST_IDLE) && start;
  assign w_accept = (r_state == ST_SCAN) && x_valid;
  assign w_last   = ((r_bitcnt + LEN_W'(1)) == r_len);

  seq_match_window #(.PAT_W(PAT_W)) u_win (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_start),
    .shift   (w_accept),
    .bit_in  (x),
    .pattern (r_pat),
    .hit     (w_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (start) w_nxt = (frame_len != '0) ? ST_SCAN : ST_DONE;
        else       w_nxt = ST_IDLE;
      end
      ST_SCAN: w_nxt = (w_accept && w_last) ? ST_DONE : ST_SCAN;
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat    <= '0;
      r_len    <= '0;
      r_bitcnt <= '0;
      r_cnt    <= '0;
      r_found  <= NOTFOUND;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= w_hit;
      if (w_start) begin
        r_pat    <= pattern;
        r_len    <= frame_len;
        r_bitcnt <= '0;
        r_cnt    <= '0;
        r_found  <= NOTFOUND;
      end else if (w_accept) begin
        r_bitcnt <= r_bitcnt + LEN_W'(1);
        if (w_hit) begin
          r_found <= FOUND;
          if (r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy        = (r_state == ST_SCAN);
  assign done        = (r_state == ST_DONE);
  assign found       = r_found;
  assign match_pulse = r_pulse;
  assign match_cnt   = r_cnt;
endmodule
